// File: rtl/pkt_proc_deq_reader_if.sv
// Dequeue-side and downstream stream signals of the packet dequeue reader.
// The master is the reader itself. The slave is the environment: the packet
// processor read port together with the egress consumer.
interface pkt_proc_deq_reader_if;
  logic        deq_req;
  logic        out_sop;
  logic [31:0] rd_data_o;
  logic        out_eop;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic        m_sop;
  logic        m_eop;
  logic        m_err;
  logic [11:0] m_len;

  modport master (
    output deq_req,
    input  out_sop, rd_data_o, out_eop,
    output m_valid, m_data, m_sop, m_eop, m_err, m_len,
    input  m_ready
  );

  modport slave (
    input  deq_req,
    output out_sop, rd_data_o, out_eop,
    input  m_valid, m_data, m_sop, m_eop, m_err, m_len,
    output m_ready
  );
endinterface

// File: rtl/pkt_proc_deq_reader.sv
// Packet dequeue reader.
// The block issues dequeue requests and absorbs the fixed read latency. It
// re-frames the returned words into packets, tagging length and missing-eop
// errors. A first-word-fall-through skip FIFO holds the words for a
// valid/ready downstream. Requests are credit-limited: buffered words plus
// in-flight requests never exceed the FIFO depth.
module pkt_proc_deq_reader #(
  parameter int RD_LATENCY = 1,
  parameter int BUF_DEPTH  = 4,
  parameter int MAX_LEN    = 2048
) (
  input  logic        pck_proc_int_mem_fsm_clk,
  input  logic        pck_proc_int_mem_fsm_rst,
  input  logic        pck_proc_int_mem_fsm_sw_rstn,
  input  logic        rd_en,
  input  logic        pck_proc_empty,
  pkt_proc_deq_reader_if.master bus,
  output logic [15:0] pkt_cnt,
  output logic [7:0]  err_cnt,
  output logic [7:0]  orphan_cnt
);

  localparam int AW = $clog2(BUF_DEPTH);
  localparam int CW = AW + 2;
  localparam int EW = 47;

  typedef enum logic {IDLE, IN_PKT} state_t;

  logic clk, rst, soft_rstn;
  assign clk       = pck_proc_int_mem_fsm_clk;
  assign rst       = pck_proc_int_mem_fsm_rst;
  assign soft_rstn = pck_proc_int_mem_fsm_sw_rstn;

  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [1:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {7'd0, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  function automatic logic [11:0] sat_inc12(input logic [11:0] a);
    return (a == 12'hFFF) ? a : a + 12'd1;
  endfunction

  logic [RD_LATENCY-1:0] req_sr;
  logic [CW-1:0]         inflight;
  logic [CW-1:0]         fifo_count;
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [EW-1:0]         mem [BUF_DEPTH];
  logic [EW-1:0]         head;
  logic                  ret_vld, pop;

  state_t       state, state_nx;
  logic [11:0]  len_cnt, len_nx;
  logic         err_pend, err_pend_nx;
  logic         push, push_sop, push_eop, push_err, pend_eff, len_err, orphan_inc;
  logic [11:0]  push_len;
  logic [1:0]   err_inc;

  // Count outstanding requests in the latency shift register.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) inflight = inflight + CW'(req_sr[i]);
  end

  // Requests are masked during either reset so no word is popped upstream unseen.
  assign bus.deq_req = ~rst & soft_rstn & rd_en & ~pck_proc_empty &
                       ((fifo_count + inflight) < CW'(BUF_DEPTH));
  assign ret_vld     = req_sr[RD_LATENCY-1];

  // Request shift register: marks which cycles carry a returned word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             req_sr <= '0;
    else if (!soft_rstn) req_sr <= '0;
    else                 req_sr <= (req_sr << 1) | RD_LATENCY'(bus.deq_req);
  end

  // Framer state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE; len_cnt <= '0; err_pend <= 1'b0;
    end else if (!soft_rstn) begin
      state <= IDLE; len_cnt <= '0; err_pend <= 1'b0;
    end else begin
      state <= state_nx; len_cnt <= len_nx; err_pend <= err_pend_nx;
    end
  end

  // Framer next state: classify each returned word and build its FIFO entry.
  always_comb begin
    state_nx    = state;
    len_nx      = len_cnt;
    err_pend_nx = err_pend;
    push        = 1'b0;
    push_sop    = 1'b0;
    push_eop    = 1'b0;
    push_err    = 1'b0;
    push_len    = '0;
    pend_eff    = 1'b0;
    len_err     = 1'b0;
    orphan_inc  = 1'b0;
    err_inc     = 2'd0;
    if (ret_vld) begin
      case (state)
        IDLE: begin
          if (bus.out_sop) begin
            push        = 1'b1;
            push_sop    = 1'b1;
            push_len    = 12'd1;
            len_nx      = 12'd1;
            err_pend_nx = 1'b0;
            if (bus.out_eop) push_eop = 1'b1;
            else             state_nx = IN_PKT;
          end else begin
            orphan_inc = 1'b1;
          end
        end
        IN_PKT: begin
          push = 1'b1;
          if (bus.out_sop) begin
            // Missing eop: the new sop restarts framing and taints the new packet.
            err_inc  = 2'd1;
            push_sop = 1'b1;
            push_len = 12'd1;
            pend_eff = 1'b1;
          end else begin
            push_len = sat_inc12(len_cnt);
            pend_eff = err_pend;
          end
          len_nx = push_len;
          if (bus.out_eop) begin
            len_err     = push_len > 12'(MAX_LEN);
            push_eop    = 1'b1;
            push_err    = len_err | pend_eff;
            err_inc     = err_inc + {1'b0, len_err};
            state_nx    = IDLE;
            err_pend_nx = 1'b0;
          end else begin
            err_pend_nx = pend_eff;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  assign head        = mem[rd_ptr];
  assign bus.m_valid = (fifo_count != '0);
  assign pop         = bus.m_valid & bus.m_ready;
  assign bus.m_sop   = bus.m_valid & head[46];
  assign bus.m_eop   = bus.m_valid & head[45];
  assign bus.m_err   = bus.m_valid & head[44];
  assign bus.m_len   = bus.m_valid ? head[43:32] : 12'd0;
  assign bus.m_data  = bus.m_valid ? head[31:0]  : 32'd0;

  // FIFO storage: data only, no reset needed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {push_sop, push_eop, push_err, push_len, bus.rd_data_o};
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0; rd_ptr <= '0; fifo_count <= '0;
    end else if (!soft_rstn) begin
      wr_ptr <= '0; rd_ptr <= '0; fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Statistics counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_cnt <= '0; err_cnt <= '0; orphan_cnt <= '0;
    end else if (!soft_rstn) begin
      pkt_cnt <= '0; err_cnt <= '0; orphan_cnt <= '0;
    end else begin
      if (pop && head[45]) pkt_cnt <= pkt_cnt + 16'd1;
      err_cnt <= sat_add8(err_cnt, err_inc);
      if (orphan_inc) orphan_cnt <= sat_add8(orphan_cnt, 2'd1);
    end
  end

endmodule
